// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the 3x3 Sobel stage: paces grayscale FIFO pops, line-buffer shifts
// (with a zero-fill flush at the end of the frame) and result pushes into the output FIFO.
module sobel_window_ctrl #(
    parameter int WIDTH    = 720,
    parameter int HEIGHT   = 540,
    parameter int CNT_W    = 19,
    parameter int PIPE_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic in_empty,
    output logic in_rd_en,
    input  logic out_full,
    output logic lb_clear,
    output logic lb_shift_en,
    output logic lb_zero_fill,
    output logic out_border,
    output logic out_wr_en,
    output logic busy,
    output logic frame_done
);

    localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(WIDTH * HEIGHT);
    localparam logic [CNT_W-1:0] LAG      = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0] in_cnt, out_cnt, out_row, out_col;
    logic             issue, border;
    logic [PIPE_LAT-1:0] issue_pipe, border_pipe;

    assign border = (out_row == '0) || (out_row == LAST_ROW) ||
                    (out_col == '0) || (out_col == LAST_COL);

    // One step per cycle at most; a stalled step leaves every strobe low.
    always_comb begin
        state_next   = state;
        in_rd_en     = 1'b0;
        lb_clear     = 1'b0;
        lb_shift_en  = 1'b0;
        lb_zero_fill = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    lb_clear   = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (!in_empty) begin
                    in_rd_en    = 1'b1;
                    lb_shift_en = 1'b1;
                    if (in_cnt + ONE == LAG) state_next = RUN;
                end
            end
            RUN: begin
                // Pop and issue together so the window stays exactly LAG pixels ahead.
                if (!in_empty && !out_full) begin
                    in_rd_en    = 1'b1;
                    lb_shift_en = 1'b1;
                    issue       = 1'b1;
                    if (in_cnt + ONE == TOTAL) state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!out_full) begin
                    lb_shift_en  = 1'b1;
                    lb_zero_fill = 1'b1;
                    issue        = 1'b1;
                    if (out_cnt + ONE == TOTAL) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            out_row     <= '0;
            out_col     <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            issue_pipe  <= '0;
            border_pipe <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != IDLE);
            frame_done <= (state_next == DONE);
            if (lb_clear) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                out_row <= '0;
                out_col <= '0;
            end else begin
                if (in_rd_en) in_cnt <= in_cnt + ONE;
                if (issue) begin
                    out_cnt <= out_cnt + ONE;
                    if (out_col == LAST_COL) begin
                        out_col <= '0;
                        out_row <= out_row + ONE;
                    end else begin
                        out_col <= out_col + ONE;
                    end
                end
            end
            // Delay line matches the datapath latency from shift to result.
            issue_pipe[0]  <= issue;
            border_pipe[0] <= issue & border;
            for (int i = 1; i < PIPE_LAT; i++) begin
                issue_pipe[i]  <= issue_pipe[i-1];
                border_pipe[i] <= border_pipe[i-1];
            end
        end
    end

    assign out_wr_en  = issue_pipe[PIPE_LAT-1];
    assign out_border = border_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a 4x3 frame: stimulus pushes the expected border
// sequence per frame, a negedge monitor pops and compares on every out_wr_en.
module tb_sobel_window_ctrl;

    logic clock = 1'b0;
    logic reset, start, in_empty, out_full;
    logic in_rd_en, lb_clear, lb_shift_en, lb_zero_fill;
    logic out_border, out_wr_en, busy, frame_done;

    int vectors     = 0;
    int miscompares = 0;

    bit exp_q[$];
    int pops, wrs, zero_fills, done_cnt, clear_cnt;
    logic prev_full, prev_done;

    localparam bit [11:0] BORDER_BITS = 12'b1111_1001_1111;

    sobel_window_ctrl #(
        .WIDTH(4), .HEIGHT(3), .CNT_W(19), .PIPE_LAT(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .in_empty(in_empty),
        .in_rd_en(in_rd_en), .out_full(out_full), .lb_clear(lb_clear),
        .lb_shift_en(lb_shift_en), .lb_zero_fill(lb_zero_fill),
        .out_border(out_border), .out_wr_en(out_wr_en), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops plus per-cycle protocol invariants.
    initial begin
        pops = 0; wrs = 0; zero_fills = 0; done_cnt = 0; clear_cnt = 0;
        prev_full = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clock);
            if (reset === 1'b1) begin
                if (lb_clear) begin
                    pops = 0; wrs = 0; zero_fills = 0; clear_cnt++;
                end
                check_output("clear_with_shift", int'(lb_clear & lb_shift_en), 0);
                check_output("clear_while_busy", int'(lb_clear & busy), 0);
                check_output("pop_while_empty", int'(in_rd_en & in_empty), 0);
                check_output("pop_during_zero_fill", int'(in_rd_en & lb_zero_fill), 0);
                check_output("pop_without_shift", int'(in_rd_en & ~lb_shift_en), 0);
                if (out_wr_en) begin
                    wrs++;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_wr", 1, 0);
                    end else begin
                        check_output($sformatf("border_%0d", wrs), int'(out_border), int'(exp_q.pop_front()));
                    end
                    check_output("lag", pops - wrs, (wrs <= 7) ? 5 : 12 - wrs);
                    check_output("wr_after_full", int'(prev_full), 0);
                end
                pops += int'(in_rd_en);
                zero_fills += int'(lb_shift_en & lb_zero_fill);
                check_output("done_pulse_width", int'(prev_done & frame_done), 0);
                if (frame_done) begin
                    done_cnt++;
                    check_output("frame_pops", pops, 12);
                    check_output("frame_wrs", wrs, 12);
                    check_output("frame_zero_fills", zero_fills, 5);
                    check_output("queue_left", exp_q.size(), 0);
                end
            end
            prev_full = out_full;
            prev_done = frame_done;
        end
    end

    task automatic check_idle(input string tag);
        check_output({tag, "_busy"}, int'(busy), 0);
        check_output({tag, "_wr"}, int'(out_wr_en), 0);
        check_output({tag, "_done"}, int'(frame_done), 0);
        check_output({tag, "_rd"}, int'(in_rd_en), 0);
        check_output({tag, "_shift"}, int'(lb_shift_en), 0);
        check_output({tag, "_clear"}, int'(lb_clear), 0);
    endtask

    // mode 0 clean, 1 empty toggling, 2 full burst, 3 stray starts, 4 random, 5 mid-RUN reset
    task automatic apply_stimulus(input int mode);
        bit finished;
        bit border_bits[12];
        finished = 1'b0;
        for (int k = 0; k < 12; k++) begin
            border_bits[k] = BORDER_BITS[11-k];
            exp_q.push_back(border_bits[k]);
        end
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check_output("busy_after_start", int'(busy), 1);
        for (int cyc = 1; cyc < 300 && !finished; cyc++) begin
            in_empty = 1'b0; out_full = 1'b0; start = 1'b0;
            case (mode)
                1: in_empty = (cyc % 2 == 1);
                2: out_full = (cyc >= 8 && cyc < 18);
                3: start = (cyc == 3 || cyc == 8 || cyc == 15);
                4: begin
                    in_empty = ($urandom_range(0, 2) == 0);
                    out_full = ($urandom_range(0, 3) == 0);
                end
                5: if (cyc == 8) reset = 1'b0;
                default: ;
            endcase
            #1;
            if (mode == 2 && out_full) begin
                check_output("rd_during_full", int'(in_rd_en), 0);
                check_output("shift_during_full", int'(lb_shift_en), 0);
            end
            @(posedge clock); #1;
            if (mode == 5 && cyc == 8) begin
                reset = 1'b1;
                exp_q.delete();
                check_idle("after_reset");
                finished = 1'b1;
            end else if (frame_done) begin
                finished = 1'b1;
            end
        end
        in_empty = 1'b0; out_full = 1'b0; start = 1'b0;
        check_output($sformatf("frame_finished_mode%0d", mode), int'(finished), 1);
        @(posedge clock); #1;
        check_output("busy_after_frame", int'(busy), 0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_empty = 1'b0; out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        check_output("reset_border", int'(out_border), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_idle("idle");
        for (int m = 0; m <= 5; m++) apply_stimulus(m);
        apply_stimulus(0);
        repeat (3) @(posedge clock);
        #1;
        check_output("frames_done", done_cnt, 6);
        check_output("frames_cleared", clear_cnt, 7);
        check_output("final_busy", int'(busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
